// File: rtl/boot_loader.sv
// boot_loader: assembles a length-prefixed, XOR-checked byte stream into instruction memory and holds the CPU until verified.
module boot_loader #(
  parameter int AWIDTH  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_wren,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR} state_t;
  state_t      state;
  logic [7:0]  len_lo, xsum;
  logic [1:0]  bcnt;
  logic [15:0] index, n_new;
  logic [31:0] word, tcnt;
  logic        xfer, counting;
  assign rx_ready   = state inside {LEN0, LEN1, DATA, CSUM};
  assign xfer       = rx_valid && rx_ready;
  assign counting   = state inside {LEN1, DATA, CSUM};
  assign n_new      = {rx_data, len_lo};
  assign imem_wren  = state == WRITE;
  assign imem_addr  = {14'd0, index, 2'b00};
  assign imem_wdata = word;
  assign cpu_hold   = state != DONE;
  assign done       = state == DONE;
  assign error      = state == ERROR;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len_lo     <= '0;
      xsum       <= '0;
      bcnt       <= '0;
      index      <= '0;
      word       <= '0;
      tcnt       <= '0;
      word_count <= '0;
    end else begin
      if (xfer) tcnt <= '0;
      else if (counting) tcnt <= tcnt + 32'd1;
      case (state)
        IDLE: begin
          state <= LEN0;
          tcnt  <= '0;
        end
        LEN0: if (xfer) begin
          len_lo <= rx_data;
          xsum   <= xsum ^ rx_data;
          state  <= LEN1;
        end
        LEN1: if (xfer) begin
          word_count <= n_new;
          xsum       <= xsum ^ rx_data;
          state      <= (32'(n_new) > (32'd1 << AWIDTH)) ? ERROR : (n_new == 16'd0) ? CSUM : DATA;
        end
        DATA: if (xfer) begin
          word  <= {rx_data, word[31:8]};
          xsum  <= xsum ^ rx_data;
          bcnt  <= bcnt + 2'd1;
          state <= (bcnt == 2'd3) ? WRITE : DATA;
        end
        WRITE: begin
          index <= index + 16'd1;
          state <= (index + 16'd1 == word_count) ? CSUM : DATA;
        end
        CSUM: if (xfer) state <= (rx_data == xsum) ? DONE : ERROR;
        default: ;
      endcase
      // an idle gap of TIMEOUT cycles mid-load aborts; overrides any transition above
      if (counting && !xfer && (tcnt + 32'd1 >= 32'(TIMEOUT))) state <= ERROR;
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed checks of framing, writes, checksum, oversize, timeout and reset behaviour.
module tb_boot_loader;
  logic        clk = 0, rst = 0;
  logic [7:0]  rx_data = 0;
  logic        rx_valid = 0;
  logic        rx_ready, imem_wren, cpu_hold, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;
  int errors = 0, checks = 0, wr_total = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  boot_loader #(.AWIDTH(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_wren(imem_wren), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_wren) begin
    if (wr_total < 64) begin
      wr_addr[wr_total] = imem_addr;
      wr_data[wr_total] = imem_wdata;
    end
    wr_total++;
  end

  task automatic send(input logic [7:0] b);
    int k = 0;
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    while (!rx_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_%h: rx_ready=%b required 1", b, rx_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rx_valid = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if ({rx_ready, imem_wren, cpu_hold, done, error} !== 5'b00100 || imem_addr !== 0 || imem_wdata !== 0 || word_count !== 0) begin
      errors++;
      $display("FAIL reset_values: rdy/wren/hold/done/err=%b%b%b%b%b addr=%h wdata=%h wc=%0d required 00100 0 0 0",
               rx_ready, imem_wren, cpu_hold, done, error, imem_addr, imem_wdata, word_count);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic run_frame(input logic [7:0] last, input logic ok);
    logic [7:0] f [11] = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h46};
    int base = wr_total;
    f[10] = last;
    for (int i = 0; i < 11; i++) begin
      send(f[i]);
      if (i == 5 || i == 9) begin
        checks++;
        if (imem_wren !== 1'b1 || rx_ready !== 1'b0 || imem_addr !== (i == 5 ? 32'h0 : 32'h4) ||
            imem_wdata !== (i == 5 ? 32'h11223344 : 32'hAABBCCDD)) begin
          errors++;
          $display("FAIL write_cycle_%0d: wren=%b rdy=%b addr=%h wdata=%h required 1 0 %h %h", i, imem_wren, rx_ready,
                   imem_addr, imem_wdata, (i == 5 ? 32'h0 : 32'h4), (i == 5 ? 32'h11223344 : 32'hAABBCCDD));
        end
      end
      if (i == 9) begin
        checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1) begin
          errors++;
          $display("FAIL early_done: done=%b hold=%b required 0 1", done, cpu_hold);
        end
      end
    end
    rx_valid = 0;
    checks++;
    if (done !== ok || cpu_hold !== !ok || error !== !ok || word_count !== 16'd2) begin
      errors++;
      $display("FAIL frame_end_%h: done=%b hold=%b err=%b wc=%0d required %b %b %b 2", last, done, cpu_hold, error,
               word_count, ok, !ok, !ok);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_total - base !== 2) begin
      errors++;
      $display("FAIL write_count: got %0d required 2", wr_total - base);
    end else begin
      checks++;
      if (wr_addr[base] !== 0 || wr_data[base] !== 32'h11223344 || wr_addr[base+1] !== 4 || wr_data[base+1] !== 32'hAABBCCDD) begin
        errors++;
        $display("FAIL write_log: %h=%h %h=%h required 0=11223344 4=aabbccdd", wr_addr[base], wr_data[base],
                 wr_addr[base+1], wr_data[base+1]);
      end
    end
  endtask

  task automatic test_good();
    do_reset();
    run_frame(8'h46, 1'b1);
  endtask

  task automatic test_bad_checksum();
    do_reset();
    run_frame(8'h47, 1'b0);
  endtask

  task automatic test_empty();
    int base;
    do_reset();
    base = wr_total;
    send(8'h00);
    send(8'h00);
    send(8'h00);
    rx_valid = 0;
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 0 || wr_total !== base) begin
      errors++;
      $display("FAIL empty: done=%b hold=%b wc=%0d writes=%0d required 1 0 0 0", done, cpu_hold, word_count, wr_total - base);
    end
  endtask

  task automatic test_oversize();
    int base;
    do_reset();
    base = wr_total;
    send(8'h05);
    send(8'h00);
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || word_count !== 16'd5) begin
      errors++;
      $display("FAIL oversize: err=%b rdy=%b wc=%0d required 1 0 5", error, rx_ready, word_count);
    end
    rx_data = 8'h11;
    repeat (5) @(posedge clk);
    #1;
    rx_valid = 0;
    checks++;
    if (rx_ready !== 1'b0 || error !== 1'b1 || wr_total !== base) begin
      errors++;
      $display("FAIL oversize_hold: rdy=%b err=%b writes=%0d required 0 1 0", rx_ready, error, wr_total - base);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'h01);
    send(8'h00);
    send(8'h44);
    rx_valid = 0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err=%b required 0 after 15 cycles", error);
    end
    @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: err=%b rdy=%b required 1 0 after 16 cycles", error, rx_ready);
    end
  endtask

  task automatic test_idle_no_timeout();
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: err=%b rdy=%b required 0 1", error, rx_ready);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send(8'h01);
    send(8'h00);
    send(8'h44);
    send(8'h33);
    rst = 0;
    #1;
    checks++;
    if (rx_ready !== 1'b0 || imem_wren !== 1'b0 || word_count !== 0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: rdy=%b wren=%b wc=%0d hold=%b required 0 0 0 1", rx_ready, imem_wren, word_count, cpu_hold);
    end
    @(negedge clk);
    rst = 1;
    run_frame(8'h46, 1'b1);
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_checksum();
    test_empty();
    test_oversize();
    test_timeout();
    test_idle_no_timeout();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
# boot_loader

Instruction-memory loader that sits directly upstream of the CPU core. It accepts a byte stream from a serial receiver and assembles little-endian 32-bit words. It writes them sequentially into instruction memory from address 0, then checks a trailing XOR checksum. It holds the CPU in reset until the image is loaded and verified; on any framing fault it stays in an error state until reset.

## Interface
- `AWIDTH`, default 10: instruction-memory word-address width; maximum image is 2^AWIDTH words.
- `TIMEOUT`, default 1000000: maximum idle cycles between accepted bytes while a load is in progress.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: asynchronous, active-low reset.
- `rx_data` in, 8: incoming byte.
- `rx_valid` in, 1: `rx_data` is valid.
- `rx_ready` out, 1: loader accepts a byte this cycle.
- `imem_wren` out, 1: one-cycle instruction-memory write strobe.
- `imem_addr` out, 32: byte address of the write, always word aligned (`4*index`).
- `imem_wdata` out, 32: assembled word.
- `cpu_hold` out, 1: high keeps the CPU in reset.
- `done` out, 1: image loaded and checksum matched.
- `error` out, 1: load failed.
- `word_count` out, 16: word count N from the header.

## Operation
- Frame format, in order:
  - LEN0, LEN1: N, little-endian, 16 bits.
  - 4*N payload bytes, little-endian per word.
  - One checksum byte: XOR of every preceding frame byte (LEN0, LEN1 and all payload bytes).
- Byte transfer happens on a cycle with `rx_valid && rx_ready`. `rx_data` is ignored otherwise.
- States and transitions:
  - IDLE: reset state. Moves to LEN0 on the first clock edge after reset release.
  - LEN0 → LEN1 on transfer.
  - LEN1 → on transfer, N is latched:
    - N > 2^AWIDTH → ERROR.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: shifts bytes into the word register as `{b3,b2,b1,b0}`. On the 4th byte → WRITE.
  - WRITE: one cycle. `imem_wren`=1, `imem_addr`=`4*index`, `imem_wdata`=word. `index` increments. If `index+1==N` → CSUM, else → DATA.
  - CSUM: on transfer, compare the received byte with the running XOR. Equal → DONE, else → ERROR.
  - DONE, ERROR: terminal; left only by reset.
- `rx_ready`=1 in LEN0, LEN1, DATA and CSUM; 0 in IDLE, WRITE, DONE and ERROR.
- Running XOR updates on every transferred byte except the checksum byte itself.
- Timeout:
  - Counter clears on each transfer and on entry to LEN0.
  - Counts in LEN0 (only after the first byte has been transferred), LEN1, DATA and CSUM.
  - Reaching TIMEOUT → ERROR.
  - LEN0 with no bytes received never times out.
- Outputs by state:
  - `cpu_hold`=1 in every state except DONE.
  - `done`=1 only in DONE; `error`=1 only in ERROR.
- `word_count` holds the latched N; it is 0 until LEN1 completes.
- Reset asserted at any point, including mid-word or during WRITE:
  - Returns to IDLE and clears the index, byte counter, XOR and timeout counter.
  - Words already written remain in memory.

## Timing
- Reset values: `rx_ready`=0, `imem_wren`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `word_count`=0.
- All outputs are registered or decoded from registered state; there is no combinational path from `rx_valid` to any output.
- Write latency: `imem_wren` pulses in the cycle immediately after the transfer of a word's 4th byte. `imem_addr` and `imem_wdata` are stable in that cycle.
- Throughput: at most 4 bytes per 5 cycles.
- DONE/ERROR latency: `done`/`cpu_hold`=0 or `error`=1 appear in the cycle after the deciding transfer, or after the timeout terminal count.
- After `rx_ready` falls, `rx_valid` may stay high; the held byte is not consumed.

## Test plan
- Good load: stream 02 00 44 33 22 11 DD CC BB AA 46 at full rate.
  - Writes 0x11223344 @0x0 and 0xAABBCCDD @0x4.
  - Exactly 2 `imem_wren` pulses.
  - `done`=1 and `cpu_hold`=0 one cycle after byte 0x46.
- Bad checksum: same stream with last byte 0x47 → both writes occur; `error`=1, `done`=0, `cpu_hold` stays 1.
- Empty image: 00 00 00 → no `imem_wren`; `done`=1; `word_count`=0.
- Oversize (AWIDTH=2): 05 00 → `error`=1 after LEN1; no writes; `rx_ready`=0 thereafter.
- Timeout (TIMEOUT=16):
  - Send 01 00 44 then stall → `error`=1 exactly 16 cycles after the 0x44 transfer.
  - With no bytes at all: no error for 100 cycles.
- Reset mid-load: assert `rst` after 01 00 44 33, then send the full good frame → `done`=1; writes start again at 0x0; the XOR excludes pre-reset bytes.
